// File: rtl/seq1011_tx_pkg.sv
// Shared types and constants for the 1011-framing serial transmitter.
// Optional bit stuffing is enabled by defining SEQ1011_TX_STUFF_EN.
package seq1011_tx_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PRE  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } state_t;

    localparam int              DEFAULT_PRE_W    = 4;
    localparam logic [3:0]      DEFAULT_PREAMBLE = 4'b1011;

    // Three emitted bits that, followed by a 1, would recreate the preamble.
    localparam logic [2:0]      STUFF_WINDOW     = 3'b101;

    // Width of a down-counter that must hold values 0..n-1 (never below 1 bit).
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/seq1011_stuff_ctrl.sv
// Bit-stuffing control for seq1011_tx (only built with SEQ1011_TX_STUFF_EN).
// The 3-bit history window is the two previously emitted bits plus the bit
// currently on the line; a 101 window during payload forces a stuffed 0 next.
module seq1011_stuff_ctrl
    import seq1011_tx_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic bit_now,
    input  logic data_phase,
    input  logic last_bit,
    output logic stuff_req
);

    logic [1:0] prev_q;
    logic [2:0] history;

    assign history   = {prev_q, bit_now};
    assign stuff_req = data_phase & ~last_bit & (history == STUFF_WINDOW);

    // Track every bit that appears on the line, preamble and stuffed bits included.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            prev_q <= '0;
        end else begin
            prev_q <= {prev_q[0], bit_now};
        end
    end

endmodule

// File: rtl/seq1011_tx.sv
// Serial transmitter for the 1011 framing protocol: accepts payload words on a
// valid/ready handshake and emits preamble, MSB-first payload, then idle zeros.
// Define SEQ1011_TX_STUFF_EN to insert a 0 after any 101 inside the payload so
// that 1011 can only appear at the start of a frame.
//
// state | meaning
// IDLE  | line at 0, in_ready high, waiting for a word
// PRE   | shifting out the preamble (PRE_W cycles)
// DATA  | shifting out the payload MSB-first (plus stuffed zeros if enabled)
// GAP   | forced zeros after the frame (GAP_BITS cycles)
module seq1011_tx
    import seq1011_tx_pkg::*;
#(
    parameter int                 DATA_W   = 8,
    parameter int                 PRE_W    = DEFAULT_PRE_W,
    parameter logic [PRE_W-1:0]   PREAMBLE = DEFAULT_PREAMBLE,
    parameter int                 GAP_BITS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              dout,
    output logic              busy,
    output logic              frame_done
);

    localparam int               CNT_W     = cnt_width(max3(DATA_W, PRE_W, GAP_BITS));
    localparam logic [CNT_W-1:0] PRE_LAST  = CNT_W'(PRE_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_BITS - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [DATA_W-1:0]  data_sh;
    logic [PRE_W-1:0]   pre_sh;
    logic               stuff_req;

    assign in_ready = (state == IDLE);

`ifdef SEQ1011_TX_STUFF_EN
    logic data_phase;
    logic last_bit;

    // In DATA the counter holds the number of payload bits still to follow the
    // one on the line, so zero marks the final payload bit.
    assign data_phase = (state == DATA);
    assign last_bit   = (cnt == '0);

    seq1011_stuff_ctrl u_stuff_ctrl (
        .clk        (clk),
        .rst        (rst),
        .bit_now    (dout),
        .data_phase (data_phase),
        .last_bit   (last_bit),
        .stuff_req  (stuff_req)
    );
`else
    assign stuff_req = 1'b0;
`endif

    // Frame sequencer; dout/busy/frame_done are registered alongside the state
    // so they describe the cycle the state register is in.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            data_sh    <= '0;
            pre_sh     <= '0;
            dout       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state   <= PRE;
                        data_sh <= in_data;
                        pre_sh  <= PREAMBLE << 1;
                        dout    <= PREAMBLE[PRE_W-1];
                        busy    <= 1'b1;
                        cnt     <= PRE_LAST;
                    end
                end
                PRE: begin
                    if (cnt == '0) begin
                        state   <= DATA;
                        dout    <= data_sh[DATA_W-1];
                        data_sh <= data_sh << 1;
                        cnt     <= DATA_LAST;
                    end else begin
                        dout    <= pre_sh[PRE_W-1];
                        pre_sh  <= pre_sh << 1;
                        cnt     <= cnt - 1'b1;
                    end
                end
                DATA: begin
                    if (stuff_req) begin
                        // Stuffed zero: payload shifter and bit count hold.
                        dout <= 1'b0;
                    end else if (cnt == '0) begin
                        state <= GAP;
                        dout  <= 1'b0;
                        busy  <= 1'b0;
                        cnt   <= GAP_LAST;
                    end else begin
                        dout       <= data_sh[DATA_W-1];
                        data_sh    <= data_sh << 1;
                        cnt        <= cnt - 1'b1;
                        frame_done <= (cnt == CNT_ONE);
                    end
                end
                GAP: begin
                    if (cnt == '0) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    dout  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/seq1011_tx.md
Name: seq1011_tx

Overview:
- Serial transmitter for the 1011 framing protocol; the source end of the single-bit `din` stream consumed by the overlapping 1011 Moore detector.
- Accepts parallel payload words over a valid/ready handshake.
- Emits each word as: preamble 1011, then the payload MSB-first, then mandatory idle zeros.
- Sits between a word-producing block and the serial line; one bit per `clk`.

Parameters:
- DATA_W, 8, payload width in bits (>=2).
- PRE_W, 4, preamble length.
- PREAMBLE, 4'b1011, preamble pattern, sent MSB-first.
- GAP_BITS, 1, zero bits forced after each frame before `in_ready` returns (>=1).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  source has a payload word.
- in_data  input  DATA_W  payload word; sampled only on acceptance.
- in_ready  output  1  block can accept a word; high only in IDLE.
- dout  output  1  registered serial bit.
- busy  output  1  high while preamble or payload bits are on `dout`.
- frame_done  output  1  one-cycle pulse, coincident with the last payload bit on `dout`.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, dout=0, busy=0, frame_done=0, in_ready=1, all counters and shift/history registers cleared.
- Reset mid-frame: the frame aborts immediately and the partial frame is lost; no resume.
- States:
  - IDLE -> PRE on acceptance (in_valid & in_ready).
  - PRE (PRE_W cycles) -> DATA.
  - DATA (DATA_W cycles, plus stuff cycles if enabled) -> GAP.
  - GAP (GAP_BITS cycles) -> IDLE.
- in_ready = (state==IDLE), decoded from registered state; no combinational path from in_valid.
- in_valid while not ready: ignored. Source holds data per standard valid/ready; no loss, no double accept.
- Latency: acceptance in cycle k -> dout carries preamble bits in cycles k+1..k+PRE_W, payload bits in k+PRE_W+1..k+PRE_W+DATA_W.
- frame_done pulses in cycle k+PRE_W+DATA_W.
- dout=0 in IDLE and GAP. Zero run between frames is at least GAP_BITS+1 bits, since the acceptance cycle is also 0.
- busy=1 exactly in PRE and DATA cycles.
- Payload is loaded into a shift register on acceptance. Shifting left MSB-first, the bit count must wrap exactly at DATA_W.

Optional Feature:
- Macro SEQ1011_TX_STUFF_EN.
- Defined:
  - A 3-bit history of emitted bits tracks every bit on dout, including preamble and stuffed bits.
  - In DATA, if the last three emitted bits are 101 and the bit just sent was not the final payload bit, the next cycle emits a stuffed 0 and the payload shift register holds.
  - No stuffing during PRE.
  - No stuff after the final payload bit; the GAP zero covers it.
  - Guarantees that 1011 appears only at frame start.
  - frame_done moves later by the number of stuffed bits; busy stays high during stuff cycles.
- Undefined: no history, no stuffing; payload is sent raw and may alias the preamble.

Decomposition:
- Package seq1011_tx_pkg: state enum (IDLE, PRE, DATA, GAP), default PREAMBLE constant, counter-width function (clog2).
- One natural sub-module, seq1011_stuff_ctrl: history register plus stuff-request logic. Instantiated only under SEQ1011_TX_STUFF_EN.

Test Plan:
- Reset with rst=0 mid-preamble at cycle 2 -> dout=0, busy=0, in_ready=1 immediately (asynchronous); next accept restarts with preamble 1.
- No stuffing, in_data=8'hA5 accepted at cycle 0:
  - dout cycles 1-12 = 1,0,1,1,1,0,1,0,0,1,0,1.
  - frame_done at 12, dout=0 at 13, in_ready=1 at 14.
- in_valid held high with 8'hA5 then 8'h3C, GAP_BITS=1:
  - second accept at cycle 14; in_ready=0 for cycles 1-13.
  - second preamble starts at cycle 15; first word is not re-sent.
- SEQ1011_TX_STUFF_EN, 8'hA5:
  - dout cycles 1-13 = 1,0,1,1,1,0,1,0,0,0,1,0,1 (stuff at cycle 8).
  - frame_done at 13.
- SEQ1011_TX_STUFF_EN, 8'hB0:
  - dout cycles 1-14 = 1,0,1,1,1,0,1,0,1,0,0,0,0,0 (stuffs at cycles 8 and 10).
  - Loopback into the 1011 detector yields exactly one detection per frame.
